// File: rtl/writeback_stage.sv
// Writeback stage: MW pipeline latch, destination/data selection and retirement counter.
// Each latched instruction issues its register-file write only in its first cycle in the stage.
module writeback_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush,
  input  logic [31:0] mw_insn,
  input  logic [31:0] mw_o,
  input  logic [31:0] mw_d,
  input  logic [31:0] mw_pc,
  input  logic        mw_exc,
  input  logic [31:0] mw_exc_code,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        wb_valid,
  output logic [31:0] wb_insn,
  output logic [31:0] retired_count
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [4:0] REG_RSTATUS = 5'd30;
  localparam logic [4:0] REG_LINK    = 5'd31;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] o;
    logic [31:0] d;
    logic [31:0] pc;
    logic        exc;
    logic [31:0] exc_code;
    logic        valid;
    logic        written;
  } mw_latch_t;

  mw_latch_t   mw_q;
  logic [31:0] retired_q;

  logic [4:0]  opcode;
  logic [4:0]  rd;
  logic [26:0] target;
  logic        write_class;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;
  logic        first_cycle;

  assign first_cycle = mw_q.valid && !mw_q.written;

  // Flush clears the whole latch so a bubble presents all-zero outputs, same as reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      mw_q <= '0;
    end else if (flush) begin
      mw_q <= '0;
    end else if (enable) begin
      mw_q.insn     <= mw_insn;
      mw_q.o        <= mw_o;
      mw_q.d        <= mw_d;
      mw_q.pc       <= mw_pc;
      mw_q.exc      <= mw_exc;
      mw_q.exc_code <= mw_exc_code;
      mw_q.valid    <= 1'b1;
      mw_q.written  <= 1'b0;
    end else if (mw_q.valid) begin
      mw_q.written  <= 1'b1;
    end
  end

  // Retirement is judged on the latch contents before the edge, whatever the edge loads.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= '0;
    end else if (first_cycle) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign opcode = mw_q.insn[31:27];
  assign rd     = mw_q.insn[26:22];
  assign target = mw_q.insn[26:0];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    write_class = 1'b0;
    sel_reg     = '0;
    sel_data    = '0;
    if (mw_q.exc) begin
      write_class = 1'b1;
      sel_reg     = REG_RSTATUS;
      sel_data    = mw_q.exc_code;
    end else begin
      unique case (opcode)
        OP_SETX: begin
          write_class = 1'b1;
          sel_reg     = REG_RSTATUS;
          sel_data    = {5'b0, target};
        end
        OP_JAL: begin
          write_class = 1'b1;
          sel_reg     = REG_LINK;
          sel_data    = mw_q.pc;
        end
        OP_LW: begin
          write_class = 1'b1;
          sel_reg     = rd;
          sel_data    = mw_q.d;
        end
        OP_RTYPE, OP_ADDI: begin
          write_class = 1'b1;
          sel_reg     = rd;
          sel_data    = mw_q.o;
        end
        default: begin
          write_class = 1'b0;
        end
      endcase
    end
  end

  assign ctrl_writeEnable = first_cycle && write_class && (sel_reg != 5'd0);
  assign ctrl_writeReg    = sel_reg;
  assign data_writeReg    = sel_data;
  assign wb_valid         = mw_q.valid;
  assign wb_insn          = mw_q.insn;
  assign retired_count    = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: each step queues its expected outputs,
// the step's clock edge is taken, and the queue head is compared against the DUT.
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        flush;
  logic [31:0] mw_insn;
  logic [31:0] mw_o;
  logic [31:0] mw_d;
  logic [31:0] mw_pc;
  logic        mw_exc;
  logic [31:0] mw_exc_code;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        wb_valid;
  logic [31:0] wb_insn;
  logic [31:0] retired_count;

  writeback_stage dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .flush            (flush),
    .mw_insn          (mw_insn),
    .mw_o             (mw_o),
    .mw_d             (mw_d),
    .mw_pc            (mw_pc),
    .mw_exc           (mw_exc),
    .mw_exc_code      (mw_exc_code),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .wb_valid         (wb_valid),
    .wb_insn          (wb_insn),
    .retired_count    (retired_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic        we;
    logic [4:0]  rg;
    logic [31:0] data;
    logic        valid;
    logic [31:0] insn;
    logic [31:0] count;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [21:0] rest);
    return {op, rd, rest};
  endfunction

  task automatic cmp32(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, field, obs, exp);
    end
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    cmp32(e.tag, "we",    {31'b0, ctrl_writeEnable}, {31'b0, e.we});
    cmp32(e.tag, "reg",   {27'b0, ctrl_writeReg},    {27'b0, e.rg});
    cmp32(e.tag, "data",  data_writeReg,             e.data);
    cmp32(e.tag, "valid", {31'b0, wb_valid},         {31'b0, e.valid});
    cmp32(e.tag, "insn",  wb_insn,                   e.insn);
    cmp32(e.tag, "count", retired_count,             e.count);
  endtask

  // Inputs are already driven; queue expectation, take the edge, compare #1 later.
  task automatic step(input string tag, input logic we, input logic [4:0] rg,
                      input logic [31:0] data, input logic valid,
                      input logic [31:0] insn, input logic [31:0] count);
    sb.push_back('{tag, we, rg, data, valid, insn, count});
    @(posedge clock);
    #1;
    compare_head();
  endtask

  task automatic drive(input logic en, input logic fl, input logic [31:0] insn,
                       input logic [31:0] o, input logic [31:0] d, input logic [31:0] pc,
                       input logic exc, input logic [31:0] code);
    enable = en; flush = fl; mw_insn = insn; mw_o = o; mw_d = d; mw_pc = pc;
    mw_exc = exc; mw_exc_code = code;
  endtask

  logic [31:0] i_add5, i_lw7, i_setx, i_jal, i_add3, i_sw, i_add0, i_sw4, i_lw9, i_addi2;

  initial begin
    i_add5  = mk(5'b00000, 5'd5, 22'h0);
    i_lw7   = mk(5'b01000, 5'd7, 22'h00010);
    i_setx  = {5'b10101, 27'h0000ABC};
    i_jal   = {5'b00011, 27'h0000040};
    i_add3  = mk(5'b00000, 5'd3, 22'h0);
    i_sw    = mk(5'b00111, 5'd6, 22'h00004);
    i_add0  = mk(5'b00000, 5'd0, 22'h0);
    i_sw4   = mk(5'b00111, 5'd4, 22'h00008);
    i_lw9   = mk(5'b01000, 5'd9, 22'h00020);
    i_addi2 = mk(5'b00101, 5'd2, 22'h00005);

    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    step("reset0", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'd0);
    step("reset1", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'd0);

    // add r5 -> strobe the cycle after capture
    reset = 1'b0;
    drive(1'b1, 1'b0, i_add5, 32'h1234, 32'h0, 32'h0, 1'b0, 32'h0);
    step("add_r5", 1'b1, 5'd5, 32'h1234, 1'b1, i_add5, 32'd0);

    // lw r7 held three cycles: one strobe, one retirement
    drive(1'b1, 1'b0, i_lw7, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 32'h0);
    step("lw_r7", 1'b1, 5'd7, 32'hDEADBEEF, 1'b1, i_lw7, 32'd1);
    enable = 1'b0;
    step("lw_hold1", 1'b0, 5'd7, 32'hDEADBEEF, 1'b1, i_lw7, 32'd2);
    step("lw_hold2", 1'b0, 5'd7, 32'hDEADBEEF, 1'b1, i_lw7, 32'd2);
    step("lw_hold3", 1'b0, 5'd7, 32'hDEADBEEF, 1'b1, i_lw7, 32'd2);

    drive(1'b1, 1'b0, i_setx, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    step("setx", 1'b1, 5'd30, 32'h00000ABC, 1'b1, i_setx, 32'd2);
    drive(1'b1, 1'b0, i_jal, 32'h0, 32'h0, 32'h40, 1'b0, 32'h0);
    step("jal", 1'b1, 5'd31, 32'h40, 1'b1, i_jal, 32'd3);

    // exceptions override the opcode, even a non-writing one
    drive(1'b1, 1'b0, i_add3, 32'h77, 32'h0, 32'h0, 1'b1, 32'h1);
    step("exc_add", 1'b1, 5'd30, 32'h1, 1'b1, i_add3, 32'd4);
    drive(1'b1, 1'b0, i_sw, 32'h0, 32'h0, 32'h0, 1'b1, 32'h55);
    step("exc_sw", 1'b1, 5'd30, 32'h55, 1'b1, i_sw, 32'd5);
    drive(1'b1, 1'b0, i_add0, 32'h9, 32'h0, 32'h0, 1'b0, 32'h0);
    step("add_r0", 1'b0, 5'd0, 32'h9, 1'b1, i_add0, 32'd6);
    drive(1'b1, 1'b0, i_sw4, 32'h11, 32'h22, 32'h33, 1'b0, 32'h0);
    step("sw_nowr", 1'b0, 5'd0, 32'h0, 1'b1, i_sw4, 32'd7);

    // flush wins over enable
    drive(1'b1, 1'b1, i_add5, 32'd77, 32'h0, 32'h0, 1'b0, 32'h0);
    step("flush_en", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'd8);
    drive(1'b0, 1'b0, i_add5, 32'd77, 32'h0, 32'h0, 1'b0, 32'h0);
    step("bubble_hold", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'd8);

    // reset during a held lw aborts it
    drive(1'b1, 1'b0, i_lw9, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, 32'h0);
    step("lw_r9", 1'b1, 5'd9, 32'hCAFEF00D, 1'b1, i_lw9, 32'd8);
    enable = 1'b0;
    step("lw9_hold", 1'b0, 5'd9, 32'hCAFEF00D, 1'b1, i_lw9, 32'd9);
    reset = 1'b1;
    step("rst_stall", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'd0);
    reset = 1'b0;
    step("post_rst", 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'd0);

    // counter wrap
    drive(1'b1, 1'b0, i_addi2, 32'h5, 32'h0, 32'h0, 1'b0, 32'h0);
    step("addi_r2", 1'b1, 5'd2, 32'h5, 1'b1, i_addi2, 32'd0);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    cmp32("wrap_forced", "count", retired_count, 32'hFFFF_FFFF);
    release dut.retired_q;
    enable = 1'b0;
    step("wrap", 1'b0, 5'd2, 32'h5, 1'b1, i_addi2, 32'd0);

    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
